// File: rtl/status_unit_pkg.sv
// -----------------------------------------------------------------------------
// status_unit_pkg
//   Shared constants for the MC6502 processor status register (P):
//   flag bit positions, P-register op encodings and reset/format constants.
//
//   Configuration macro: STATUS_DECIMAL_EN
//     defined   : D flag is stored and writable.
//     undefined : D flag is hardwired to 0 (2A03 variant).
// -----------------------------------------------------------------------------
package status_unit_pkg;

    // Bit positions inside P, layout {N,V,_,B,D,I,Z,C}
    localparam int C_FLAG_SHFT_C = 0;
    localparam int C_FLAG_SHFT_Z = 1;
    localparam int C_FLAG_SHFT_I = 2;
    localparam int C_FLAG_SHFT_D = 3;
    localparam int C_FLAG_SHFT_B = 4;
    localparam int C_FLAG_SHFT_U = 5;
    localparam int C_FLAG_SHFT_V = 6;
    localparam int C_FLAG_SHFT_N = 7;

    // P-register operations driven by the control sequencer
    localparam logic [2:0] C_P_OP_NOP      = 3'd0;
    localparam logic [2:0] C_P_OP_ALU      = 3'd1;
    localparam logic [2:0] C_P_OP_SET      = 3'd2;
    localparam logic [2:0] C_P_OP_CLR      = 3'd3;
    localparam logic [2:0] C_P_OP_PULL     = 3'd4;
    localparam logic [2:0] C_P_OP_INTENTER = 3'd5;

    // Reset value of P: I set, unused bit 5 reads as 1
    localparam logic [7:0] C_P_RESET = 8'h24;

    // Bits that always read as 1 regardless of the stored state
    localparam logic [7:0] C_P_FIXED = 8'h20;

    // Bits that are actually held in the register; everything else is forced
`ifdef STATUS_DECIMAL_EN
    localparam logic [7:0] C_P_STORED = 8'hCF;
`else
    localparam logic [7:0] C_P_STORED = 8'hC7;
`endif

    // Canonical form of a P value: drop non-stored bits, force bit 5 high
    function automatic logic [7:0] p_format(input logic [7:0] raw);
        return (raw & C_P_STORED) | C_P_FIXED;
    endfunction

endpackage

// File: rtl/status_unit_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
//   Single-bit rising-edge detector with registered output.
//   rise is high for one cycle, the cycle after the edge clock where
//   din = 1 was sampled while the previous sample was 0.
//
//   Ports:
//     clk  in  : clock
//     srst in  : synchronous active-high reset
//     din  in  : input level
//     rise out : registered one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic rise
);

    logic din_q_reg;
    logic rise_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            din_q_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            din_q_reg <= din;
            rise_reg  <= din & ~din_q_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/status_unit.sv
// -----------------------------------------------------------------------------
// status_unit
//   MC6502 processor status register (P) plus NMI/IRQ pending logic.
//
//   Ports:
//     CLK       in  1 : core clock
//     RST       in  1 : synchronous active-high reset
//     OP        in  3 : P operation (C_P_OP_*)
//     ALU_FLAG  in  8 : ALU flag result {N,V,_,B,D,I,Z,C}
//     ALU_WE    in  8 : per-bit write mask for the ALU op
//     BIT_SEL   in  3 : flag index for SET/CLR
//     DIN       in  8 : byte pulled from stack (PULL)
//     PUSH_B    in  1 : B bit value inserted into PUSH_DATA
//     SYNC      in  1 : instruction boundary strobe
//     IRQ       in  1 : level interrupt request
//     NMI       in  1 : edge interrupt request (rising edge)
//     NMI_ACK   in  1 : sequencer has taken the NMI vector
//     FLAG      out 8 : current P
//     PUSH_DATA out 8 : P formatted for stack push
//     INT_PEND  out 1 : interrupt to be taken at the next SYNC
//     NMI_PEND  out 1 : pending interrupt is an NMI
//
//   Configuration macro: STATUS_DECIMAL_EN (see status_unit_pkg).
// -----------------------------------------------------------------------------
module status_unit
    import status_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] OP,
    input  logic [7:0] ALU_FLAG,
    input  logic [7:0] ALU_WE,
    input  logic [2:0] BIT_SEL,
    input  logic [7:0] DIN,
    input  logic       PUSH_B,
    input  logic       SYNC,
    input  logic       IRQ,
    input  logic       NMI,
    input  logic       NMI_ACK,
    output logic [7:0] FLAG,
    output logic [7:0] PUSH_DATA,
    output logic       INT_PEND,
    output logic       NMI_PEND
);

    logic [7:0] p_reg;
    logic [7:0] p_next;
    logic [7:0] alu_merge;
    logic [7:0] op_result;
    logic       irq_mask_reg;
    logic       nmi_pend_reg;
    logic       nmi_rise;

    // Per-bit merge of the ALU result under its write mask. Non-stored bits
    // (B, bit 5, and D when decimal is disabled) are normalised afterwards.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_alu_merge
            assign alu_merge[gi] = ALU_WE[gi] ? ALU_FLAG[gi] : p_reg[gi];
        end
    endgenerate

    always_comb begin
        op_result = p_reg;
        unique case (OP)
            C_P_OP_ALU:      op_result = alu_merge;
            C_P_OP_SET:      op_result[BIT_SEL] = 1'b1;
            C_P_OP_CLR:      op_result[BIT_SEL] = 1'b0;
            C_P_OP_PULL:     op_result = DIN;
            C_P_OP_INTENTER: op_result[C_FLAG_SHFT_I] = 1'b1;
            default:         op_result = p_reg;
        endcase
        // SET/CLR on bits 4/5 and any write to a non-stored D vanish here
        p_next = p_format(op_result);
    end

    // Registered NMI edge; pending register adds the second cycle of latency
    edge_detect u_nmi_edge (
        .clk  (CLK),
        .srst (RST),
        .din  (NMI),
        .rise (nmi_rise)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_reg        <= C_P_RESET;
            irq_mask_reg <= 1'b1;
            nmi_pend_reg <= 1'b0;
        end else begin
            p_reg <= p_next;
            // Mask only follows I at instruction boundaries, which gives
            // CLI/SEI/PLP their one-instruction-delayed effect on IRQ.
            if (SYNC) begin
                irq_mask_reg <= p_next[C_FLAG_SHFT_I];
            end
            // A new edge beats a simultaneous ack so it is not lost
            nmi_pend_reg <= nmi_rise | (nmi_pend_reg & ~NMI_ACK);
        end
    end

    assign FLAG      = p_reg;
    assign PUSH_DATA = {p_reg[7:5], PUSH_B, p_reg[3:0]};
    assign INT_PEND  = nmi_pend_reg | (IRQ & ~irq_mask_reg);
    assign NMI_PEND  = nmi_pend_reg;

endmodule

// File: tb/tb_status_unit.sv
// -----------------------------------------------------------------------------
// tb_status_unit
//   Self-checking bench for status_unit: directed test-plan sequence followed
//   by randomized cycles, all compared against a flag-level reference model.
// -----------------------------------------------------------------------------
module tb_status_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic [7:0] alu_flag;
    logic [7:0] alu_we;
    logic [2:0] bit_sel;
    logic [7:0] din;
    logic       push_b;
    logic       sync;
    logic       irq;
    logic       nmi;
    logic       nmi_ack;
    logic [7:0] flag;
    logic [7:0] push_data;
    logic       int_pend;
    logic       nmi_pend;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    status_unit dut (
        .CLK       (clk),
        .RST       (rst),
        .OP        (op),
        .ALU_FLAG  (alu_flag),
        .ALU_WE    (alu_we),
        .BIT_SEL   (bit_sel),
        .DIN       (din),
        .PUSH_B    (push_b),
        .SYNC      (sync),
        .IRQ       (irq),
        .NMI       (nmi),
        .NMI_ACK   (nmi_ack),
        .FLAG      (flag),
        .PUSH_DATA (push_data),
        .INT_PEND  (int_pend),
        .NMI_PEND  (nmi_pend)
    );

`ifdef STATUS_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    // ---------------- reference model ----------------
    // Flags are kept as a plain byte in {N,V,1,0,D,I,Z,C} form.
    logic [7:0] m_p;
    logic       m_mask;      // IRQ mask as seen at the last instruction boundary
    logic       m_nmi_last;  // NMI level seen at the previous clock
    logic       m_nmi_seen;  // a rising edge was observed at the previous clock
    logic       m_pend;

    function automatic logic [7:0] model_flags(input logic [7:0] p_in);
        logic [7:0] q;
        q = p_in;
        case (op)
            3'd1: for (int k = 0; k < 8; k++) if (alu_we[k]) q[k] = alu_flag[k];
            3'd2: q[bit_sel] = 1'b1;
            3'd3: q[bit_sel] = 1'b0;
            3'd4: q = din;
            3'd5: q[2] = 1'b1;
            default: q = p_in;
        endcase
        q[5] = 1'b1;
        q[4] = 1'b0;
        if (!DEC_EN) q[3] = 1'b0;
        return q;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %02h expected %02h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: advance model with the inputs present at the edge, then
    // compare every output 1 time unit after the edge.
    task automatic tick();
        logic [7:0] np;
        logic       npend;
        @(posedge clk);
        if (rst) begin
            m_p = 8'h24; m_mask = 1'b1; m_nmi_last = 1'b0; m_nmi_seen = 1'b0; m_pend = 1'b0;
        end else begin
            np    = model_flags(m_p);
            npend = m_nmi_seen | (m_pend & ~nmi_ack);
            m_nmi_seen = nmi & ~m_nmi_last;
            m_nmi_last = nmi;
            if (sync) m_mask = np[2];
            m_p    = np;
            m_pend = npend;
        end
        #1;
        cyc++;
        check("flag",      flag,      m_p);
        check("push_data", push_data, {m_p[7:5], push_b, m_p[3:0]});
        check("int_pend",  {7'd0, int_pend}, {7'd0, m_pend | (irq & ~m_mask)});
        check("nmi_pend",  {7'd0, nmi_pend}, {7'd0, m_pend});
        $display("cyc %0d rst=%0b op=%0d sel=%0d sync=%0b irq=%0b nmi=%0b ack=%0b -> flag=%02h push=%02h int=%0b nmi_p=%0b",
                 cyc, rst, op, bit_sel, sync, irq, nmi, nmi_ack, flag, push_data, int_pend, nmi_pend);
    endtask

    task automatic set_op(input logic [2:0] o, input logic [2:0] sel, input logic [7:0] d, input logic s);
        op = o; bit_sel = sel; din = d; sync = s;
    endtask

    initial begin
        rst = 1'b1; op = 3'd0; alu_flag = 8'h00; alu_we = 8'h00; bit_sel = 3'd0;
        din = 8'h00; push_b = 1'b1; sync = 1'b0; irq = 1'b1; nmi = 1'b0; nmi_ack = 1'b0;
        m_p = 8'h24; m_mask = 1'b1; m_nmi_last = 1'b0; m_nmi_seen = 1'b0; m_pend = 1'b0;

        // Reset and release
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_flag", flag, 8'h24);
        check("rst_push_b1", push_data, 8'h34);
        check("rst_int_pend", {7'd0, int_pend}, 8'h00);
        push_b = 1'b0; #1;
        check("rst_push_b0", push_data, 8'h24);

        // ALU op under mask
        alu_flag = 8'hFF; alu_we = 8'hC3; set_op(3'd1, 3'd0, 8'h00, 1'b0);
        tick();
        check("alu_c3", flag, 8'hE7);

        // PULL all ones / all zeros
        set_op(3'd4, 3'd0, 8'hFF, 1'b0);
        tick();
        check("pull_ff", flag, DEC_EN ? 8'hEF : 8'hE7);
        set_op(3'd4, 3'd0, 8'h00, 1'b0);
        tick();
        check("pull_00", flag, 8'h20);

        // IRQ latency: mask follows I only at SYNC
        set_op(3'd2, 3'd2, 8'h00, 1'b1); tick();   // SEI at boundary
        set_op(3'd3, 3'd2, 8'h00, 1'b0); tick();   // CLI, no boundary
        check("cli_no_sync", {7'd0, int_pend}, 8'h00);
        set_op(3'd0, 3'd0, 8'h00, 1'b1); tick();
        check("cli_after_sync", {7'd0, int_pend}, 8'h01);
        set_op(3'd2, 3'd2, 8'h00, 1'b1); tick();
        check("sei_with_sync", {7'd0, int_pend}, 8'h00);

        // NMI edge, ack, held level, ack coinciding with new edge
        irq = 1'b0; set_op(3'd0, 3'd0, 8'h00, 1'b0);
        nmi = 1'b1; tick();
        check("nmi_lat1", {7'd0, nmi_pend}, 8'h00);
        tick();
        check("nmi_lat2", {7'd0, nmi_pend}, 8'h01);
        nmi_ack = 1'b1; tick();
        nmi_ack = 1'b0; tick(); tick();
        check("nmi_held_no_rearm", {7'd0, nmi_pend}, 8'h00);
        nmi = 1'b0; tick();
        nmi = 1'b1; tick(); tick();
        nmi = 1'b0; tick();
        nmi = 1'b1; tick();
        nmi_ack = 1'b1; tick();
        check("nmi_edge_with_ack", {7'd0, nmi_pend}, 8'h01);
        nmi_ack = 1'b1; tick();
        nmi_ack = 1'b0;
        check("nmi_ack_clears", {7'd0, nmi_pend}, 8'h00);

        // INTENTER from 0x20, then mask re-arms at SYNC
        set_op(3'd4, 3'd0, 8'h00, 1'b1); tick();
        irq = 1'b1; #1;
        check("irq_open", {7'd0, int_pend}, 8'h01);
        set_op(3'd5, 3'd0, 8'h00, 1'b0); tick();
        check("intenter_flag", flag, 8'h24);
        set_op(3'd0, 3'd0, 8'h00, 1'b1); tick();
        check("intenter_mask", {7'd0, int_pend}, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            op       = 3'($urandom_range(0, 7));
            alu_flag = 8'($urandom);
            alu_we   = 8'($urandom);
            bit_sel  = 3'($urandom_range(0, 7));
            din      = 8'($urandom);
            push_b   = 1'($urandom_range(0, 1));
            sync     = ($urandom_range(0, 2) == 0);
            irq      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) nmi = ~nmi;
            nmi_ack  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/status_unit.md
# status_unit

Processor status register (P) and interrupt-pending logic for the MC6502 core. Holds the N V D I Z C flags, feeds them to the ALU flag input, and accepts the ALU flag result under a per-bit write mask. Also services flag set/clear instructions, stack push/pull formatting, interrupt entry, and the NMI/IRQ pending decision at instruction boundaries. Sits beside the ALU inside the datapath and is driven by the control sequencer.

## Interface
- No parameters.
- `CLK` in 1: core clock.
- `RST` in 1: synchronous, active-high reset.
- `OP` in 3: operation code; one of `C_P_OP_*`.
- `ALU_FLAG` in 8: ALU flag output; bit layout is `{N,V,_,B,D,I,Z,C}`.
- `ALU_WE` in 8: per-bit write mask used by the ALU op.
- `BIT_SEL` in 3: flag bit index used by the SET and CLR ops.
- `DIN` in 8: byte pulled from the stack, used by the PULL op.
- `PUSH_B` in 1: value of the B bit in `PUSH_DATA`.
- `SYNC` in 1: high for one cycle at each instruction boundary (opcode fetch).
- `IRQ` in 1: level interrupt request, active-high.
- `NMI` in 1: edge interrupt request, active on the rising edge.
- `NMI_ACK` in 1: sequencer has taken the NMI vector.
- `FLAG` out 8: current P register, driven to the ALU flag input.
- `PUSH_DATA` out 8: P value formatted for stack push.
- `INT_PEND` out 1: an interrupt must be taken at the next `SYNC`.
- `NMI_PEND` out 1: the pending interrupt is an NMI.

## Operation
- Stored flags are N, V, D, I, Z and C. B and bit 5 are not stored.
- `FLAG` = `{N,V,1,0,D,I,Z,C}`.
- `PUSH_DATA` = `{N,V,1,PUSH_B,D,I,Z,C}`. It is combinational from the stored flags.
- Ops, all applied on the `CLK` edge:
  - NOP (0): hold.
  - ALU (1): for each stored bit k, the new value is `ALU_WE[k] ? ALU_FLAG[k] : old`. Mask bits 5 and 4 are ignored.
  - SET (2): stored bit `BIT_SEL` is set to 1.
  - CLR (3): stored bit `BIT_SEL` is cleared to 0.
  - SET and CLR with `BIT_SEL` = 4 or 5 have no effect.
  - PULL (4): stored flags are loaded from `DIN`. `DIN[5:4]` is ignored.
  - INTENTER (5): I is set to 1. All other flags hold.
  - Codes 6 and 7 behave as NOP.
- IRQ mask latency:
  - `irq_mask` is a register loaded with the post-op I value on every cycle where `SYNC` = 1.
  - This gives CLI, SEI and PLP their one-instruction-delayed effect on IRQ.
  - An op and `SYNC` in the same cycle: `irq_mask` takes the new I.
- NMI:
  - `NMI` is registered once; a rising edge is the condition `nmi_q` = 0 and `NMI` = 1.
  - The edge sets `nmi_pend`. `NMI_ACK` clears it.
  - An edge and an ack in the same cycle leave `nmi_pend` = 1, so the new edge is not lost.
  - A held-high `NMI` produces no further edges.
- `INT_PEND` = `nmi_pend | (IRQ & ~irq_mask)`.
- `NMI_PEND` = `nmi_pend`.

## Timing
- Reset values:
  - Flags: N=V=D=Z=C=0, I=1.
  - `FLAG` = 8'h24.
  - `PUSH_DATA` = 8'h24 with `PUSH_B`=0, 8'h34 with `PUSH_B`=1.
  - `irq_mask`=1, `nmi_q`=0, `nmi_pend`=0.
  - `INT_PEND`=0, `NMI_PEND`=0.
- `RST` has priority over all ops. A reset mid-instruction discards pending NMI.
- Op latency: `FLAG` reflects an op on the cycle after the edge.
- NMI: `NMI_PEND` rises 2 cycles after `NMI` rises (input register, then pending register).
- IRQ: `IRQ` to `INT_PEND` is combinational once `irq_mask`=0.

## Configuration
- Macro `STATUS_DECIMAL_EN`.
- Defined: D is writable by ALU, SET, CLR and PULL.
- Undefined: D is hardwired to 0, as on the 2A03 variant. All writes to D are ignored, and `FLAG[3]` = `PUSH_DATA[3]` = 0.

## Structure
- `params.vh` holds:
  - the existing `C_FLAG_SHFT_*` bit indices;
  - new `C_P_OP_NOP`, `C_P_OP_ALU`, `C_P_OP_SET`, `C_P_OP_CLR`, `C_P_OP_PULL` and `C_P_OP_INTENTER` encodings;
  - the reset constant `C_P_RESET = 8'h24`.
- One sub-module, `edge_detect`: a single-bit rising-edge detector with synchronous reset, used for `NMI`.

## Test plan
- Reset then release:
  - `FLAG`=8'h24.
  - With `PUSH_B`=1: `PUSH_DATA`=8'h34.
  - With `PUSH_B`=0: `PUSH_DATA`=8'h24.
  - `INT_PEND`=0 even with `IRQ`=1.
- ALU op, `ALU_FLAG`=8'hFF, `ALU_WE`=8'hC3: `FLAG`=8'hE7.
- PULL, `DIN`=8'hFF: with `STATUS_DECIMAL_EN` `FLAG`=8'hEF; without it `FLAG`=8'hE7.
- PULL, `DIN`=8'h00: `FLAG`=8'h20.
- IRQ latency: `IRQ`=1, CLR `BIT_SEL`=2 with `SYNC`=0.
  - `INT_PEND` stays 0.
  - `INT_PEND`=1 the cycle after the next `SYNC`.
  - SET I with `SYNC` in the same cycle: `INT_PEND`=0 the next cycle.
- NMI:
  - Pulse `NMI` 0→1: `NMI_PEND`=1 two cycles later.
  - Hold `NMI` high and assert `NMI_ACK`: pending clears and does not re-arm.
  - A new edge coinciding with `NMI_ACK`: `NMI_PEND` remains 1.
- INTENTER with `FLAG`=8'h20: `FLAG`=8'h24. A later `SYNC` sets `irq_mask`=1.
